pmem_line_responder: RTL

Synthesizable physical-memory responder for the line-based pmem interface driven by the L1 cache. It accepts one 128-bit line read or write at a time and holds a programmable access latency. It returns read data with a single-cycle `pmem_resp` pulse. It replaces the behavioural memory model in the system top and in cache-level benches.

---
 rtl/pmem_line_responder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pmem_line_responder.sv
// rtl/pmem_line_responder.sv - line-based pmem responder with programmable access latency
//
// Accepts one 128-bit line read or write at a time from the L1 cache, holds it
// for LATENCY cycles, commits the access, and pulses pmem_resp for one cycle.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   pmem_read      line read request (level, held until pmem_resp)
//   pmem_write     line write request (level, held until pmem_resp)
//   pmem_address   byte address; bits [INDEX_BITS+3:4] select the line
//   pmem_wdata     write line, byte 0 in bits [7:0]
//   pmem_resp      one-cycle completion pulse
//   pmem_rdata     read line; held until the next read completes
//   busy           transaction in flight (BUSY or RESP)
//   protocol_err   sticky flag: read and write accepted together
//   rd_count       completed reads, saturating
//   wr_count       completed writes, saturating

module pmem_line_responder #(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned INDEX_BITS = 12
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [127:0] pmem_rdata,
  output logic         busy,
  output logic         protocol_err,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int unsigned LINES  = 1 << INDEX_BITS;
  localparam logic [7:0]  LAT_M1 = 8'(LATENCY - 1);

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [INDEX_BITS-1:0]   idx_q;
  logic [127:0]            wdata_q;
  logic                    is_wr_q;
  logic                    req;
  logic                    accept;
  logic                    complete;

  // Line storage is deliberately not reset.
  logic [127:0]            mem [0:LINES-1];

  assign req  = pmem_read | pmem_write;
  assign busy = (state_q != ST_IDLE);

  // Byte-offset bits and any address bits above the index never select storage.
  logic unused_addr;
  generate
    if (INDEX_BITS + 4 < 16) begin : g_addr_hi
      assign unused_addr = ^{pmem_address[15:INDEX_BITS+4], pmem_address[3:0]};
    end else begin : g_addr_full
      assign unused_addr = ^pmem_address[3:0];
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    complete = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          accept  = 1'b1;
          cnt_d   = LAT_M1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Dropping both request lines abandons the access with no side effects.
        if (!req) begin
          cnt_d   = 8'd0;
          state_d = ST_IDLE;
        end else if (cnt_q == 8'd0) begin
          complete = 1'b1;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      idx_q        <= '0;
      wdata_q      <= '0;
      is_wr_q      <= 1'b0;
      pmem_resp    <= 1'b0;
      pmem_rdata   <= '0;
      protocol_err <= 1'b0;
      rd_count     <= 16'd0;
      wr_count     <= 16'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pmem_resp <= complete;
      if (accept) begin
        idx_q   <= pmem_address[INDEX_BITS+3:4];
        wdata_q <= pmem_wdata;
        // Write wins when both lines are raised together.
        is_wr_q <= pmem_write;
        if (pmem_read && pmem_write) begin
          protocol_err <= 1'b1;
        end
      end
      if (complete) begin
        if (is_wr_q) begin
          if (wr_count != 16'hFFFF) begin
            wr_count <= wr_count + 16'd1;
          end
        end else begin
          pmem_rdata <= mem[idx_q];
          if (rd_count != 16'hFFFF) begin
            rd_count <= rd_count + 16'd1;
          end
        end
      end
    end
  end

  // complete is derived from the async-reset state, so a reset in flight
  // suppresses the commit.
  always_ff @(posedge clk) begin
    if (complete && is_wr_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule
